// File: rtl/ysyx_22050058_mem_arbiter.sv
// Shares the core's single memory port between instruction fetch (IF) and load/store (LS),
// one transaction at a time, with a watchdog abort. Define YSYX_22050058_ARB_RR_EN for round-robin ties.
module ysyx_22050058_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch requester
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  // load/store requester
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  // downstream memory port
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  // pipeline controller stall requests and watchdog error
  output logic                stall_ifreq_o,
  output logic                stall_memreq_o,
  output logic                err_o
);

  localparam int         MASK_W    = DATA_W / 8;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q, last_d;
  owner_e      winner;
  logic [7:0]  wdog_q, wdog_d;

  logic        grant;
  logic        done;
  logic        abort;
  logic        timeout;
  logic        rvalid;
  logic [DATA_W-1:0] rdata;

  // Tie-break between simultaneous requests seen in IDLE.
  always_comb begin : arbitrate
`ifdef YSYX_22050058_ARB_RR_EN
    if (if_req_i && ls_req_i) begin
      winner = (last_q == OWN_IF) ? OWN_LS : OWN_IF;
    end else begin
      winner = ls_req_i ? OWN_LS : OWN_IF;
    end
`else
    winner = ls_req_i ? OWN_LS : OWN_IF;
`endif
  end

  assign timeout = (wdog_q == WDOG_LAST);

  always_comb begin : fsm_next
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    grant   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (if_req_i || ls_req_i) begin
          owner_d = winner;
          wdog_d  = 8'd0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        wdog_d = wdog_q + 8'd1;
        if (timeout) begin
          // Abort still grants so the owner never waits on a gnt that will not come.
          abort   = 1'b1;
          grant   = 1'b1;
          state_d = S_IDLE;
        end else if (mem_ready_i) begin
          grant   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        wdog_d = wdog_q + 8'd1;
        if (mem_rvalid_i) begin
          // A response arriving on the timeout cycle wins over the abort.
          done    = 1'b1;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // Downstream request and payload, muxed from the current owner while in REQ.
  assign mem_req_o = (state_q == S_REQ);

  always_comb begin : payload_mux
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (state_q == S_REQ) begin
      if (owner_q == OWN_LS) begin
        mem_we_o    = ls_we_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
        mem_wmask_o = MASK_W'(ls_wmask_i);
      end else begin
        mem_addr_o  = if_addr_i;
      end
    end
  end

  // Response routing: only the owner sees gnt/rvalid/rdata; an abort returns zero data.
  assign rvalid = done | abort;
  assign rdata  = done ? mem_rdata_i : '0;

  assign if_gnt_o    = grant  & (owner_q == OWN_IF);
  assign ls_gnt_o    = grant  & (owner_q == OWN_LS);
  assign if_rvalid_o = rvalid & (owner_q == OWN_IF);
  assign ls_rvalid_o = rvalid & (owner_q == OWN_LS);
  assign if_rdata_o  = (owner_q == OWN_IF) ? rdata : '0;
  assign ls_rdata_o  = (owner_q == OWN_LS) ? rdata : '0;
  assign err_o       = abort;

  assign stall_ifreq_o  = if_req_i & ~if_rvalid_o;
  assign stall_memreq_o = ls_req_i & ~ls_rvalid_o;

endmodule
